fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined core. It sits directly downstream of the PC-select mux and upstream of the decode stage. It owns the architectural PC register, produces `pc_current` and the sequential `add_pc_out` that feed the mux, and issues requests to instruction memory over a request/grant/response handshake. It loads fetched instructions into the IF/ID pipeline register, handling stall, flush and redirect.

---
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request/grant/response handshake, fills IF/ID.
// Optional feature: FETCH_MISALIGN_CHK_EN adds a sticky fetch_misalign flag that parks fetch on a misaligned redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_redirect,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_current,
    output logic [31:0] add_pc_out,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_PARK = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic        drop_q;
    logic [31:0] pc_q;
    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;
    logic        if_id_valid_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc_plus4_q;
    logic        misalign_q;
    logic        misalign_hit;
    logic [31:0] target_d;
    logic [31:0] pc_plus4_d;
    logic        flush_any;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_d       = pc_next;
    assign misalign_hit   = pc_redirect && (pc_next[1:0] != 2'b00);
    assign fetch_misalign = misalign_q;
`else
    assign target_d       = {pc_next[31:2], 2'b00};
    assign misalign_hit   = 1'b0;
    assign misalign_q     = 1'b0;
`endif

    assign pc_plus4_d     = pc_q + 32'd4;
    assign flush_any      = flush || pc_redirect;

    assign imem_req       = req_q && !reset;
    assign imem_addr      = pc_q;
    assign pc_current     = pc_q;
    assign add_pc_out     = pc_plus4_d;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_REQ;
            req_q            <= 1'b1;
            pc_q             <= RESET_PC;
            buf_valid_q      <= 1'b0;
            buf_pc_q         <= '0;
            buf_instr_q      <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= '0;
            if_id_instr_q    <= '0;
            if_id_pc_plus4_q <= '0;
            // A transaction in flight at reset still owes a response; remember to swallow it.
            if (state_q == S_WAIT)
                drop_q <= !imem_rvalid;
            else if (imem_rvalid)
                drop_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q       <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (misalign_hit)
                misalign_q <= 1'b1;
`endif
            if (flush_any) begin
                if_id_valid_q <= 1'b0;
                buf_valid_q   <= 1'b0;
            end else if (!stall) begin
                if_id_valid_q <= 1'b0;
            end

            case (state_q)
                S_REQ: begin
                    // A stale response may still arrive here after a reset.
                    if (drop_q && imem_rvalid)
                        drop_q <= 1'b0;
                    if (pc_redirect) begin
                        pc_q <= target_d;
                        if (imem_gnt) begin
                            state_q <= S_WAIT;
                            req_q   <= 1'b0;
                            drop_q  <= 1'b1;
                        end else if (misalign_hit) begin
                            state_q <= S_PARK;
                            req_q   <= 1'b0;
                        end
                    end else if (imem_gnt) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (pc_redirect) begin
                        pc_q <= target_d;
                        if (imem_rvalid) begin
                            drop_q  <= 1'b0;
                            state_q <= misalign_hit ? S_PARK : S_REQ;
                            req_q   <= !misalign_hit;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= misalign_q ? S_PARK : S_REQ;
                            req_q   <= !misalign_q;
                        end else begin
                            pc_q <= pc_plus4_d;
                            if (flush) begin
                                state_q <= S_REQ;
                                req_q   <= 1'b1;
                            end else if (!stall) begin
                                if_id_valid_q    <= 1'b1;
                                if_id_pc_q       <= pc_q;
                                if_id_instr_q    <= imem_rdata;
                                if_id_pc_plus4_q <= pc_plus4_d;
                                state_q          <= S_REQ;
                                req_q            <= 1'b1;
                            end else begin
                                buf_valid_q <= 1'b1;
                                buf_pc_q    <= pc_q;
                                buf_instr_q <= imem_rdata;
                                state_q     <= S_HOLD;
                                req_q       <= 1'b0;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (pc_redirect) begin
                        pc_q    <= target_d;
                        state_q <= misalign_hit ? S_PARK : S_REQ;
                        req_q   <= !misalign_hit;
                    end else if (flush) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end else if (!stall) begin
                        if_id_valid_q    <= buf_valid_q;
                        if_id_pc_q       <= buf_pc_q;
                        if_id_instr_q    <= buf_instr_q;
                        if_id_pc_plus4_q <= buf_pc_q + 32'd4;
                        buf_valid_q      <= 1'b0;
                        state_q          <= S_REQ;
                        req_q            <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_PARK;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with hand-written reset and misalign sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_redirect, stall, flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_current, add_pc_out;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr, if_id_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_redirect   (pc_redirect),
        .stall         (stall),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_current    (pc_current),
        .add_pc_out    (add_pc_out),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    typedef struct {
        logic        rd;
        logic [31:0] pn;
        logic        st, fl, g, rv;
        logic [31:0] rdat;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc, ins;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic rd, input logic [31:0] pn,
                                input logic st, input logic fl, input logic g, input logic rv,
                                input logic [31:0] rdat, input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] ipc, input logic [31:0] ins);
        vec_t t;
        t.rd = rd; t.pn = pn; t.st = st; t.fl = fl; t.g = g; t.rv = rv; t.rdat = rdat;
        t.req = req; t.addr = addr; t.vld = vld; t.ipc = ipc; t.ins = ins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] pn, input logic st, input logic fl,
                         input logic g, input logic rv, input logic [31:0] rdat);
        pc_redirect = rd; pc_next = pn; stall = st; flush = fl;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Each row: inputs driven during the cycle, outputs expected during that same cycle.
        tbl[0]  = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h0,        0, 32'h0,        32'h0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 32'hA000_0000, 0, 32'h0,       0, 32'h0,        32'h0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h4,        1, 32'h0,        32'hA000_0000);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 32'hA000_0004, 0, 32'h4,       0, 32'h0,        32'hA000_0000);
        tbl[4]  = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h8,        1, 32'h4,        32'hA000_0004);
        tbl[5]  = mk(1, 32'h100, 0, 0, 0, 0, 0,      0, 32'h8,        0, 32'h4,        32'hA000_0004);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 32'hDEAD_0008, 0, 32'h100,     0, 32'h4,        32'hA000_0004);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h100,      0, 32'h4,        32'hA000_0004);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h100,      0, 32'h4,        32'hA000_0004);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 32'hA000_0100, 0, 32'h100,     0, 32'h4,        32'hA000_0004);
        tbl[10] = mk(0, 0, 1, 0, 1, 0, 0,            1, 32'h104,      1, 32'h100,      32'hA000_0100);
        tbl[11] = mk(0, 0, 1, 0, 0, 1, 32'hA000_0104, 0, 32'h104,     1, 32'h100,      32'hA000_0100);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 0,            0, 32'h108,      1, 32'h100,      32'hA000_0100);
        tbl[13] = mk(0, 0, 1, 0, 0, 0, 0,            0, 32'h108,      1, 32'h100,      32'hA000_0100);
        tbl[14] = mk(0, 0, 1, 0, 0, 0, 0,            0, 32'h108,      1, 32'h100,      32'hA000_0100);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,            0, 32'h108,      1, 32'h100,      32'hA000_0100);
        tbl[16] = mk(1, 32'h200, 0, 0, 1, 0, 0,      1, 32'h108,      1, 32'h104,      32'hA000_0104);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 32'hBAD0_0108, 0, 32'h200,     0, 32'h104,      32'hA000_0104);
        tbl[18] = mk(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 1, 32'h200,     0, 32'h104,      32'hA000_0104);
        tbl[19] = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFF8, 0, 32'h104,     32'hA000_0104);
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 32'h1111_1FF8, 0, 32'hFFFF_FFF8, 0, 32'h104,    32'hA000_0104);
        tbl[21] = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h1111_1FF8);
        tbl[22] = mk(0, 0, 0, 0, 0, 1, 32'h1111_1FFC, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFF8, 32'h1111_1FF8);
        tbl[23] = mk(0, 0, 0, 0, 1, 0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC, 32'h1111_1FFC);
        tbl[24] = mk(0, 0, 0, 1, 0, 0, 0,            0, 32'h0,        0, 32'hFFFF_FFFC, 32'h1111_1FFC);
        tbl[25] = mk(0, 0, 0, 0, 0, 1, 32'h2222_0000, 0, 32'h0,       0, 32'hFFFF_FFFC, 32'h1111_1FFC);
        tbl[26] = mk(0, 0, 0, 1, 0, 0, 0,            1, 32'h4,        1, 32'h0,        32'h2222_0000);
`ifdef FETCH_MISALIGN_CHK_EN
        tbl[27] = mk(1, 32'h300, 0, 0, 0, 0, 0,      1, 32'h4,        0, 32'h0,        32'h2222_0000);
`else
        tbl[27] = mk(1, 32'h303, 0, 0, 0, 0, 0,      1, 32'h4,        0, 32'h0,        32'h2222_0000);
`endif
        tbl[28] = mk(0, 0, 0, 0, 0, 0, 0,            1, 32'h300,      0, 32'h0,        32'h2222_0000);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",    {31'd0, imem_req},    32'd0);
        chk("rst_addr",   imem_addr,            32'h0);
        chk("rst_pc",     pc_current,           32'h0);
        chk("rst_add4",   add_pc_out,           32'h4);
        chk("rst_valid",  {31'd0, if_id_valid}, 32'd0);
        chk("rst_ifpc",   if_id_pc,             32'h0);
        chk("rst_instr",  if_id_instr,          32'h0);
        chk("rst_plus4",  if_id_pc_plus4,       32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            logic [31:0] exp_p4;
            drive(tbl[i].rd, tbl[i].pn, tbl[i].st, tbl[i].fl, tbl[i].g, tbl[i].rv, tbl[i].rdat);
            #1;
            // IF/ID plus4 is zero only while IF/ID still holds its reset contents.
            exp_p4 = (tbl[i].ipc == 32'h0 && tbl[i].ins == 32'h0) ? 32'h0 : tbl[i].ipc + 32'd4;
            chk($sformatf("row%0d_req", i),   {31'd0, imem_req},    {31'd0, tbl[i].req});
            chk($sformatf("row%0d_addr", i),  imem_addr,            tbl[i].addr);
            chk($sformatf("row%0d_pc", i),    pc_current,           tbl[i].addr);
            chk($sformatf("row%0d_add4", i),  add_pc_out,           tbl[i].addr + 32'd4);
            chk($sformatf("row%0d_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].vld});
            chk($sformatf("row%0d_ifpc", i),  if_id_pc,             tbl[i].ipc);
            chk($sformatf("row%0d_instr", i), if_id_instr,          tbl[i].ins);
            chk($sformatf("row%0d_plus4", i), if_id_pc_plus4,       exp_p4);
            @(negedge clk);
        end

        // Reset while waiting on a response; the late response must be swallowed.
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("rw_req_before", {31'd0, imem_req}, 32'd1);
        chk("rw_addr_before", imem_addr, 32'h300);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rw_req_in_reset", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_DEAD);
        #1;
        chk("rw_req_after", {31'd0, imem_req}, 32'd1);
        chk("rw_addr_after", imem_addr, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("rw_stale_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rw_stale_addr", imem_addr, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h3333_0000);
        #1;
        chk("rw_wait_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rw_first_valid", {31'd0, if_id_valid}, 32'd1);
        chk("rw_first_pc",    if_id_pc,             32'h0);
        chk("rw_first_instr", if_id_instr,          32'h3333_0000);
        chk("rw_first_plus4", if_id_pc_plus4,       32'h4);
        chk("rw_next_addr",   imem_addr,            32'h4);

`ifdef FETCH_MISALIGN_CHK_EN
        @(negedge clk);
        drive(1, 32'h102, 0, 0, 0, 0, 0);
        #1;
        chk("ma_before", {31'd0, fetch_misalign}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            #1;
            chk($sformatf("ma_flag%0d", k), {31'd0, fetch_misalign}, 32'd1);
            chk($sformatf("ma_req%0d", k),  {31'd0, imem_req},       32'd0);
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
